fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the register/ALU block. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and latches the returned 16-bit instruction. It splits the instruction into the 8-bit opcode used by control and the 8-bit immediate fed to the register/ALU block's extenders. It accepts PC redirects (branch/jump/kernel entry) from control.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_pc_reg.sv | 70 +++++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit_pkg
// Brief   : Shared types and constants for the instruction fetch stage:
//           FSM state encoding, instruction field positions, PC defaults.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

  // Instruction field positions within the 16-bit IR
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  // Default PC behaviour: 16-bit instructions, byte addressed
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [15:0] DEF_PC_STEP  = 16'd2;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pc_reg
// Brief   : Program counter with +PC_STEP incrementer, redirect alignment
//           check and a single pending-redirect slot used while a fetch is
//           outstanding.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter logic [15:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_in_wait,      // FSM is in WAIT
  input  logic        i_ack,          // memory ack this cycle
  input  logic        i_pc_load,
  input  logic [15:0] i_pc_target,
  output logic [15:0] o_pc,
  output logic [15:0] o_fetch_pc,     // address to use for a fetch started now
  output logic        o_misalign_rej, // strobe: redirect rejected for bit 0
  output logic        o_redirect      // at ack: a redirect overrides the data
);

  logic        r_pend_vld;
  logic [15:0] r_pend_pc;
  logic [15:0] r_pc;
  logic        w_aligned_load;
  logic [15:0] w_redirect_pc;

  assign o_misalign_rej = i_pc_load & i_pc_target[0];
  assign w_aligned_load = i_pc_load & ~i_pc_target[0];

  // A fetch issued in the same cycle as a redirect uses the new target
  assign o_fetch_pc    = w_aligned_load ? i_pc_target : r_pc;

  // A redirect coincident with ack counts as pending; the newest target wins
  assign o_redirect    = r_pend_vld | w_aligned_load;
  assign w_redirect_pc = w_aligned_load ? i_pc_target : r_pend_pc;

  assign o_pc = r_pc;

  // PC and pending-redirect update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= RESET_PC;
    end else if (!i_in_wait) begin
      r_pend_vld <= 1'b0;
      if (w_aligned_load) begin
        r_pc <= i_pc_target;
      end
    end else if (i_ack) begin
      r_pend_vld <= 1'b0;
      if (o_redirect) begin
        r_pc <= w_redirect_pc;
      end else begin
        r_pc <= r_pc + PC_STEP;  // wraps modulo 2^16
      end
    end else if (w_aligned_load) begin
      r_pend_vld <= 1'b1;
      r_pend_pc  <= i_pc_target;
    end
  end

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Instruction fetch stage. Issues req/ack word reads to instruction
//           memory, latches the returned instruction into IR, and splits it
//           into opcode and immediate. Accepts PC redirects from control.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter logic [15:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [7:0]  opcode,
  output logic [7:0]  immediate,
  output logic [15:0] pc,
  output logic        busy,
  output logic        misaligned
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic        r_req;
  logic [15:0] r_addr;
  logic [15:0] r_ir;
  logic        r_valid;
  logic        r_misaligned;

  logic        w_req_nxt;
  logic [15:0] w_addr_nxt;
  logic [15:0] w_ir_nxt;
  logic        w_valid_nxt;

  logic [15:0] w_fetch_pc;
  logic        w_misalign_rej;
  logic        w_redirect;
  logic        w_aligned_load;
  logic        w_start;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clock          (clock),
    .reset          (reset),
    .i_in_wait      (r_state == ST_WAIT),
    .i_ack          (imem_ack),
    .i_pc_load      (pc_load),
    .i_pc_target    (pc_target),
    .o_pc           (pc),
    .o_fetch_pc     (w_fetch_pc),
    .o_misalign_rej (w_misalign_rej),
    .o_redirect     (w_redirect)
  );

  // A misaligned redirect suppresses fetch_en for that cycle
  assign w_aligned_load = pc_load & ~w_misalign_rej;
  assign w_start        = fetch_en & ~w_misalign_rej;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start)  w_state_nxt = ST_WAIT;
      ST_WAIT: if (imem_ack) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values for the registered handshake and IR outputs
  always_comb begin
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_ir_nxt    = r_ir;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_aligned_load) begin
          w_valid_nxt = 1'b0;
        end
        if (w_start) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = w_fetch_pc;
          w_valid_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          w_req_nxt = 1'b0;
          if (!w_redirect) begin
            w_ir_nxt    = imem_rdata;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_req_nxt = 1'b0;
      end
    endcase
  end

  // Output registers; misaligned is sticky until reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_ir         <= 16'h0000;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_req        <= w_req_nxt;
      r_addr       <= w_addr_nxt;
      r_ir         <= w_ir_nxt;
      r_valid      <= w_valid_nxt;
      r_misaligned <= r_misaligned | w_misalign_rej;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = r_valid;
  assign opcode      = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign immediate   = r_ir[IMM_MSB:IMM_LSB];
  assign busy        = (r_state == ST_WAIT);
  assign misaligned  = r_misaligned;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Directed, table-driven bench for fetch_unit. Each record holds the
//           inputs for one clock edge and the outputs expected after it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        fetch_en;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [7:0]  opcode;
  logic [7:0]  immediate;
  logic [15:0] pc;
  logic        busy;
  logic        misaligned;

  int n_vec;
  int n_bad;

  fetch_unit #(
    .RESET_PC (16'h0000),
    .PC_STEP  (16'd2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .immediate   (immediate),
    .pc          (pc),
    .busy        (busy),
    .misaligned  (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        fen;
    logic        ld;
    logic [15:0] tgt;
    logic        ack;
    logic [15:0] rdata;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_vld;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
    logic        e_busy;
    logic        e_mis;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic rst, input logic fen, input logic ld, input logic [15:0] tgt,
    input logic ack, input logic [15:0] rdata,
    input logic e_req, input logic [15:0] e_addr, input logic e_vld,
    input logic [15:0] e_ir, input logic [15:0] e_pc, input logic e_busy,
    input logic e_mis);
    vec_t v;
    v.rst = rst; v.fen = fen; v.ld = ld; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_ir = e_ir;
    v.e_pc = e_pc; v.e_busy = e_busy; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic fen, input logic ld,
                       input logic [15:0] tgt, input logic ack,
                       input logic [15:0] rdata);
    @(negedge clock);
    reset      = rst;
    fetch_en   = fen;
    pc_load    = ld;
    pc_target  = tgt;
    imem_ack   = ack;
    imem_rdata = rdata;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic e_req, input logic [15:0] e_addr,
                       input logic e_vld, input logic [15:0] e_ir,
                       input logic [15:0] e_pc, input logic e_busy,
                       input logic e_mis);
    logic [7:0] e_op;
    logic [7:0] e_imm;
    e_op  = e_ir[15:8];
    e_imm = e_ir[7:0];
    n_vec++;
    if (imem_req !== e_req || imem_addr !== e_addr || instr_valid !== e_vld ||
        opcode !== e_op || immediate !== e_imm || pc !== e_pc ||
        busy !== e_busy || misaligned !== e_mis) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h vld=%b op=%h imm=%h pc=%h busy=%b mis=%b, want req=%b addr=%h vld=%b op=%h imm=%h pc=%h busy=%b mis=%b",
               tag, imem_req, imem_addr, instr_valid, opcode, immediate, pc, busy,
               misaligned, e_req, e_addr, e_vld, e_op, e_imm, e_pc, e_busy, e_mis);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    fetch_en   = 1'b0;
    pc_load    = 1'b0;
    pc_target  = 16'h0000;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;

    //            rst fen ld tgt       ack rdata      req addr      vld ir        pc        busy mis
    // reset, then a zero-wait fetch
    tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0);
    tbl[2]  = mk(0, 0, 0, 16'h0000, 1, 16'h3A7F,   0, 16'h0000, 1, 16'h3A7F, 16'h0002, 0, 0);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 1, 16'h3A7F, 16'h0002, 0, 0);
    // three wait states; fetch_en during WAIT ignored
    tbl[4]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0002, 0, 16'h3A7F, 16'h0002, 1, 0);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 0, 16'hDEAD,   1, 16'h0002, 0, 16'h3A7F, 16'h0002, 1, 0);
    tbl[6]  = mk(0, 1, 0, 16'h0000, 0, 16'hDEAD,   1, 16'h0002, 0, 16'h3A7F, 16'h0002, 1, 0);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 0, 16'hDEAD,   1, 16'h0002, 0, 16'h3A7F, 16'h0002, 1, 0);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 1, 16'h1234,   0, 16'h0002, 1, 16'h1234, 16'h0004, 0, 0);
    // redirect together with fetch in IDLE
    tbl[9]  = mk(0, 1, 1, 16'h0100, 0, 16'h0000,   1, 16'h0100, 0, 16'h1234, 16'h0100, 1, 0);
    tbl[10] = mk(0, 0, 0, 16'h0000, 1, 16'hABCD,   0, 16'h0100, 1, 16'hABCD, 16'h0102, 0, 0);
    // redirect mid-WAIT drops the returning data
    tbl[11] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0102, 0, 16'hABCD, 16'h0102, 1, 0);
    tbl[12] = mk(0, 0, 1, 16'h0200, 0, 16'h0000,   1, 16'h0102, 0, 16'hABCD, 16'h0102, 1, 0);
    tbl[13] = mk(0, 0, 0, 16'h0000, 1, 16'hFFFF,   0, 16'h0102, 0, 16'hABCD, 16'h0200, 0, 0);
    // two redirects in WAIT, the later one coincident with ack: latest wins
    tbl[14] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0200, 0, 16'hABCD, 16'h0200, 1, 0);
    tbl[15] = mk(0, 0, 1, 16'h0300, 0, 16'h0000,   1, 16'h0200, 0, 16'hABCD, 16'h0200, 1, 0);
    tbl[16] = mk(0, 0, 1, 16'h0400, 1, 16'h5555,   0, 16'h0200, 0, 16'hABCD, 16'h0400, 0, 0);
    // misaligned redirect in IDLE: flag set, pc held, fetch_en ignored
    tbl[17] = mk(0, 1, 1, 16'h0011, 0, 16'h0000,   0, 16'h0200, 0, 16'hABCD, 16'h0400, 0, 1);
    // misaligned redirect at ack in WAIT: ignored apart from the flag
    tbl[18] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0400, 0, 16'hABCD, 16'h0400, 1, 1);
    tbl[19] = mk(0, 0, 1, 16'h0013, 1, 16'h0102,   0, 16'h0400, 1, 16'h0102, 16'h0402, 0, 1);
    // redirect-only to FFFE clears valid; fetch there wraps pc to 0000
    tbl[20] = mk(0, 0, 1, 16'hFFFE, 0, 16'h0000,   0, 16'h0400, 0, 16'h0102, 16'hFFFE, 0, 1);
    tbl[21] = mk(0, 1, 0, 16'h0000, 0, 16'h0000,   1, 16'hFFFE, 0, 16'h0102, 16'hFFFE, 1, 1);
    tbl[22] = mk(0, 0, 0, 16'h0000, 1, 16'h8001,   0, 16'hFFFE, 1, 16'h8001, 16'h0000, 0, 1);
    // ack in IDLE ignored
    tbl[23] = mk(0, 0, 0, 16'h0000, 1, 16'h7777,   0, 16'hFFFE, 1, 16'h8001, 16'h0000, 0, 1);
    // reset mid-fetch, then a late ack
    tbl[24] = mk(0, 1, 1, 16'h0500, 0, 16'h0000,   1, 16'h0500, 0, 16'h8001, 16'h0500, 1, 1);
    tbl[25] = mk(1, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[26] = mk(0, 0, 0, 16'h0000, 1, 16'h4242,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].fen, tbl[i].ld, tbl[i].tgt, tbl[i].ack, tbl[i].rdata);
      check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
            tbl[i].e_ir, tbl[i].e_pc, tbl[i].e_busy, tbl[i].e_mis);
    end

    // Back-to-back: fetch_en and imem_ack both held high. One fetch per two
    // cycles; the ack seen in IDLE on the issue cycle must be ignored.
    for (int k = 0; k < 4; k++) begin
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] prev_ir;
      a       = 16'(2 * k);
      d       = 16'hC000 + 16'(k);
      prev_ir = (k == 0) ? 16'h0000 : 16'hC000 + 16'(k - 1);
      drive(0, 1, 0, 16'h0000, 1, 16'hEEEE);
      check($sformatf("b2b_issue%0d", k), 1'b1, a, 1'b0, prev_ir, a, 1'b1, 1'b0);
      drive(0, 1, 0, 16'h0000, 1, d);
      check($sformatf("b2b_ack%0d", k), 1'b0, a, 1'b1, d, a + 16'd2, 1'b0, 1'b0);
    end

    // Long wait with held request: address and req must not move
    drive(0, 1, 0, 16'h0000, 0, 16'h0000);
    for (int w = 0; w < 5; w++) begin
      drive(0, 0, 0, 16'h0000, 0, 16'h9999);
      check($sformatf("hold%0d", w), 1'b1, 16'h0008, 1'b0, 16'hC003, 16'h0008, 1'b1, 1'b0);
    end
    drive(0, 0, 0, 16'h0000, 1, 16'h6A05);
    check("hold_ack", 1'b0, 16'h0008, 1'b1, 16'h6A05, 16'h000A, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
